// File: rtl/prol16_run_ctrl.sv
// PROL16 test-run sequencer: holds the CPU in reset, streams a program image
// into the shared memory, then releases the CPU and watches for halt,
// illegal instruction or timeout. Owns the memory bus in every state.
module prol16_run_ctrl #(
  parameter int gDataWidth = 16,
  parameter int gMemWords  = 65536,
  parameter int gMaxCycles = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start_i,
  input  logic                  ld_valid_i,
  input  logic [gDataWidth-1:0] ld_data_i,
  input  logic                  ld_last_i,
  output logic                  ld_ready_o,
  output logic                  cpu_res_o,
  input  logic [gDataWidth-1:0] cpu_mem_addr_i,
  input  logic [gDataWidth-1:0] cpu_mem_data_i,
  input  logic                  cpu_mem_ce_ni,
  input  logic                  cpu_mem_oe_ni,
  input  logic                  cpu_mem_we_ni,
  output logic [gDataWidth-1:0] cpu_mem_data_o,
  input  logic                  cpu_halt_i,
  input  logic                  cpu_illegal_i,
  output logic [gDataWidth-1:0] mem_addr_o,
  output logic [gDataWidth-1:0] mem_data_o,
  input  logic [gDataWidth-1:0] mem_data_i,
  output logic                  mem_ce_no,
  output logic                  mem_oe_no,
  output logic                  mem_we_no,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [1:0]            err_o,
  output logic [31:0]           cycle_cnt_o,
  output logic [gDataWidth:0]   load_cnt_o
);

  typedef enum logic [2:0] {IDLE, LOAD, RELEASE, RUN, HALTED, FAULT} state_t;

  localparam logic [gDataWidth:0] LAST_ADDR = (gDataWidth+1)'(gMemWords - 1);
  localparam bit                  TMO_EN    = (gMaxCycles != 0);
  localparam logic [31:0]         TMO_LAST  = TMO_EN ? 32'(gMaxCycles - 1) : 32'd0;

  state_t              r_state, w_next;
  logic [31:0]         r_cycle_cnt;
  logic [gDataWidth:0] r_load_cnt;   // doubles as the load word address
  logic [1:0]          r_err, w_err;
  logic                r_done, w_done;
  logic                w_hs, w_start, w_timeout;

  assign w_hs      = (r_state == LOAD) && ld_valid_i;
  assign w_start   = start_i && (r_state == IDLE || r_state == HALTED || r_state == FAULT);
  assign w_timeout = TMO_EN && (r_cycle_cnt == TMO_LAST);

  // state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // next state plus the error/done flags that are latched on exit
  always_comb begin
    w_next = r_state;
    w_err  = r_err;
    w_done = r_done;
    case (r_state)
      IDLE, HALTED, FAULT: if (w_start) begin
        w_next = LOAD;
        w_err  = 2'd0;
        w_done = 1'b0;
      end
      LOAD: if (w_hs) begin
        if (ld_last_i) w_next = RELEASE;
        else if (r_load_cnt == LAST_ADDR) begin
          w_next = FAULT;
          w_err  = 2'd3;
        end
      end
      RELEASE: w_next = RUN;
      RUN: begin
        if (cpu_illegal_i) begin
          w_next = FAULT;
          w_err  = 2'd1;
        end else if (cpu_halt_i) begin
          w_next = HALTED;
          w_done = 1'b1;
        end else if (w_timeout) begin
          w_next = FAULT;
          w_err  = 2'd2;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  // counters and status flags; start clears, RUN counts every cycle incl. the exit one
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cycle_cnt <= '0;
      r_load_cnt  <= '0;
      r_err       <= '0;
      r_done      <= 1'b0;
    end else begin
      r_err  <= w_err;
      r_done <= w_done;
      if (w_start) begin
        r_cycle_cnt <= '0;
        r_load_cnt  <= '0;
      end else begin
        if (w_hs) r_load_cnt <= r_load_cnt + 1'b1;
        if (r_state == RUN && r_cycle_cnt != '1) r_cycle_cnt <= r_cycle_cnt + 1'b1;
      end
    end
  end

  // memory bus ownership: loader writes on handshakes, CPU mirrored in RUN
  always_comb begin
    mem_addr_o = '0;
    mem_data_o = '0;
    mem_ce_no  = 1'b1;
    mem_oe_no  = 1'b1;
    mem_we_no  = 1'b1;
    if (w_hs) begin
      mem_addr_o = r_load_cnt[gDataWidth-1:0];
      mem_data_o = ld_data_i;
      mem_ce_no  = 1'b0;
      mem_we_no  = 1'b0;
    end else if (r_state == RUN) begin
      mem_addr_o = cpu_mem_addr_i;
      mem_data_o = cpu_mem_data_i;
      mem_ce_no  = cpu_mem_ce_ni;
      mem_oe_no  = cpu_mem_oe_ni;
      mem_we_no  = cpu_mem_we_ni;
    end
  end

  assign cpu_mem_data_o = mem_data_i;
  assign ld_ready_o     = (r_state == LOAD);
  assign cpu_res_o      = (r_state != RUN);
  assign busy_o         = (r_state == LOAD) || (r_state == RELEASE) || (r_state == RUN);
  assign done_o         = r_done;
  assign err_o          = r_err;
  assign cycle_cnt_o    = r_cycle_cnt;
  assign load_cnt_o     = r_load_cnt;

endmodule

// File: tb/tb_prol16_run_ctrl.sv
// Directed bench for prol16_run_ctrl: load/halt, gapped stream, illegal+halt,
// timeout, overflow, boundary last word, reset mid-RUN and restart.
module tb_prol16_run_ctrl;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          start_i, ld_valid_i, ld_last_i, ld_ready_o, cpu_res_o;
  logic [DW-1:0] ld_data_i, cpu_mem_addr_i, cpu_mem_data_i, cpu_mem_data_o;
  logic          cpu_mem_ce_ni, cpu_mem_oe_ni, cpu_mem_we_ni, cpu_halt_i, cpu_illegal_i;
  logic [DW-1:0] mem_addr_o, mem_data_o, mem_data_i;
  logic          mem_ce_no, mem_oe_no, mem_we_no, busy_o, done_o;
  logic [1:0]    err_o;
  logic [31:0]   cycle_cnt_o;
  logic [DW:0]   load_cnt_o;

  int checks = 0;
  int errors = 0;

  prol16_run_ctrl #(.gDataWidth(DW), .gMemWords(4), .gMaxCycles(10)) dut (
    .clk(clk), .reset(reset), .start_i(start_i),
    .ld_valid_i(ld_valid_i), .ld_data_i(ld_data_i), .ld_last_i(ld_last_i),
    .ld_ready_o(ld_ready_o), .cpu_res_o(cpu_res_o),
    .cpu_mem_addr_i(cpu_mem_addr_i), .cpu_mem_data_i(cpu_mem_data_i),
    .cpu_mem_ce_ni(cpu_mem_ce_ni), .cpu_mem_oe_ni(cpu_mem_oe_ni), .cpu_mem_we_ni(cpu_mem_we_ni),
    .cpu_mem_data_o(cpu_mem_data_o), .cpu_halt_i(cpu_halt_i), .cpu_illegal_i(cpu_illegal_i),
    .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o), .mem_data_i(mem_data_i),
    .mem_ce_no(mem_ce_no), .mem_oe_no(mem_oe_no), .mem_we_no(mem_we_no),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
    .cycle_cnt_o(cycle_cnt_o), .load_cnt_o(load_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // advance to 1 time unit after the next rising edge
  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  // present one load word, verify the write it produces, then clock it in
  task automatic load_word(input logic [DW-1:0] d, input logic last, input logic [DW-1:0] addr);
    ld_valid_i = 1'b1; ld_data_i = d; ld_last_i = last;
    #1;
    chk("ld_ready", ld_ready_o, 1);
    chk("wr_addr", mem_addr_o, addr);
    chk("wr_data", mem_data_o, d);
    chk("wr_strobes", {mem_ce_no, mem_oe_no, mem_we_no}, 3'b010);
    nxt();
    ld_valid_i = 1'b0; ld_last_i = 1'b0;
  endtask

  task automatic gap();
    ld_valid_i = 1'b0;
    #1;
    chk("gap_strobes", {mem_ce_no, mem_oe_no, mem_we_no}, 3'b111);
    nxt();
  endtask

  task automatic do_start();
    start_i = 1'b1;
    nxt();
    start_i = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start_i = 0; ld_valid_i = 0; ld_last_i = 0; ld_data_i = '0;
    cpu_mem_addr_i = '0; cpu_mem_data_i = '0;
    cpu_mem_ce_ni = 1; cpu_mem_oe_ni = 1; cpu_mem_we_ni = 1;
    cpu_halt_i = 0; cpu_illegal_i = 0; mem_data_i = 16'hBEEF;
    #2;
    chk("rst_cpu_res", cpu_res_o, 1);
    chk("rst_ld_ready", ld_ready_o, 0);
    chk("rst_strobes", {mem_ce_no, mem_oe_no, mem_we_no}, 3'b111);
    chk("rst_addr_data", {mem_addr_o, mem_data_o}, 32'h0);
    chk("rst_flags", {busy_o, done_o, err_o}, 4'b0000);
    chk("rst_counts", {cycle_cnt_o, 15'd0, load_cnt_o}, 64'h0);
    chk("rd_passthru", cpu_mem_data_o, 16'hBEEF);
    nxt();
    reset = 1'b0;
    nxt();
    chk("idle_cpu_res", cpu_res_o, 1);

    // 1: load three words, halt in the 5th RUN cycle
    do_start();
    chk("load_busy", busy_o, 1);
    load_word(16'h1111, 0, 16'd0);
    load_word(16'h2222, 0, 16'd1);
    load_word(16'h3333, 1, 16'd2);
    chk("rel_cpu_res", cpu_res_o, 1);
    chk("rel_ld_ready", ld_ready_o, 0);
    chk("rel_strobes", {mem_ce_no, mem_oe_no, mem_we_no}, 3'b111);
    chk("rel_load_cnt", load_cnt_o, 3);
    nxt();
    cpu_mem_addr_i = 16'h0042; cpu_mem_data_i = 16'h00AB;
    cpu_mem_ce_ni = 0; cpu_mem_oe_ni = 0; cpu_mem_we_ni = 1;
    #1;
    chk("run_cpu_res", cpu_res_o, 0);
    chk("run_mirror_addr", mem_addr_o, 16'h0042);
    chk("run_mirror_strb", {mem_ce_no, mem_oe_no, mem_we_no}, 3'b001);
    nxt();
    cpu_mem_oe_ni = 1; cpu_mem_we_ni = 0;
    #1;
    chk("run_mirror_wr", {mem_data_o, mem_ce_no, mem_oe_no, mem_we_no}, {16'h00AB, 3'b010});
    nxt();
    start_i = 1'b1;           // ignored in RUN
    nxt();
    start_i = 1'b0;
    nxt();
    cpu_halt_i = 1'b1;        // 5th RUN cycle
    nxt();
    cpu_halt_i = 1'b0;
    cpu_mem_ce_ni = 1; cpu_mem_oe_ni = 1; cpu_mem_we_ni = 1;
    chk("t1_halt_flags", {busy_o, done_o, err_o, cpu_res_o}, 5'b0_1_00_1);
    chk("t1_load_cnt", load_cnt_o, 3);
    chk("t1_cycle_cnt", cycle_cnt_o, 5);

    // 2+3: gapped stream, then illegal and halt together in RUN
    do_start();
    chk("t2_cleared", {done_o, cycle_cnt_o, 15'd0, load_cnt_o}, 64'h0);
    load_word(16'hAAAA, 0, 16'd0);
    gap();
    gap();
    chk("t2_gap_cnt", load_cnt_o, 1);
    load_word(16'hBBBB, 0, 16'd1);
    load_word(16'hCCCC, 1, 16'd2);
    nxt();                    // RELEASE -> RUN
    cpu_halt_i = 1; cpu_illegal_i = 1;
    #1;
    chk("t3_run", cpu_res_o, 0);
    nxt();
    cpu_halt_i = 0; cpu_illegal_i = 0;
    chk("t3_fault", {busy_o, done_o, err_o, cpu_res_o}, 5'b0_0_01_1);
    chk("t3_counts", {cycle_cnt_o, 15'd0, load_cnt_o}, {32'd1, 32'd3});

    // 4: timeout after 10 RUN cycles
    do_start();
    load_word(16'h0F0F, 1, 16'd0);
    nxt();
    for (int i = 0; i < 10; i++) begin
      chk("t4_running", {cpu_res_o, cycle_cnt_o}, {1'b0, 32'(i)});
      nxt();
    end
    chk("t4_fault", {busy_o, done_o, err_o, cpu_res_o}, 5'b0_0_10_1);
    chk("t4_cycle_cnt", cycle_cnt_o, 10);

    // 5: overflow, 5 words into a 4-word memory
    do_start();
    load_word(16'h5000, 0, 16'd0);
    load_word(16'h5001, 0, 16'd1);
    load_word(16'h5002, 0, 16'd2);
    load_word(16'h5003, 0, 16'd3);
    chk("t5_fault", {busy_o, err_o, ld_ready_o}, 4'b0_11_0);
    chk("t5_load_cnt", load_cnt_o, 4);
    ld_valid_i = 1; ld_data_i = 16'h5004; ld_last_i = 1;
    #1;
    chk("t5_ignored", {mem_ce_no, mem_we_no}, 2'b11);
    nxt();
    ld_valid_i = 0; ld_last_i = 0;
    chk("t5_hold", {err_o, load_cnt_o}, {2'b11, 17'd4});

    // 6: last word exactly at the top address is legal, then reset mid-RUN
    do_start();
    load_word(16'h6000, 0, 16'd0);
    load_word(16'h6001, 0, 16'd1);
    load_word(16'h6002, 0, 16'd2);
    load_word(16'h6003, 1, 16'd3);
    chk("t6_release", {cpu_res_o, busy_o, err_o}, 4'b1_1_00);
    nxt();
    cpu_mem_ce_ni = 0; cpu_mem_oe_ni = 0;
    nxt();
    nxt();
    reset = 1'b1;
    #1;
    chk("t6_rst_state", {cpu_res_o, ld_ready_o, busy_o, done_o, err_o}, 6'b1_0_0_0_00);
    chk("t6_rst_bus", {mem_addr_o, mem_ce_no, mem_oe_no, mem_we_no}, {16'h0, 3'b111});
    chk("t6_rst_counts", {cycle_cnt_o, 15'd0, load_cnt_o}, 64'h0);
    cpu_mem_ce_ni = 1; cpu_mem_oe_ni = 1;
    nxt();
    reset = 1'b0;
    do_start();
    load_word(16'h7000, 0, 16'd0);
    load_word(16'h7001, 1, 16'd1);
    nxt();
    nxt();
    cpu_halt_i = 1;
    nxt();
    cpu_halt_i = 0;
    chk("t6_halted", {done_o, err_o, cycle_cnt_o, 15'd0, load_cnt_o}, {1'b1, 2'b00, 32'd2, 32'd2});
    do_start();
    chk("t6_restart_clr", {done_o, err_o, cycle_cnt_o, 15'd0, load_cnt_o}, {3'b000, 64'h0});
    load_word(16'h8000, 1, 16'd0);
    chk("t6_reload_cnt", load_cnt_o, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/prol16_run_ctrl.md
Name: prol16_run_ctrl

Overview:
- Sequences one PROL16 test run: holds the CPU in reset, loads a program image into the shared 16-bit memory from a word stream, then releases the CPU.
- While the CPU runs, monitors halt and illegal-instruction flags and counts cycles to a timeout.
- Sits between the CPU memory port and the memory and owns the memory bus: loader during LOAD, CPU during RUN, idle otherwise.

Parameters:
- gDataWidth, 16, data/address width (matches CPU).
- gMemWords, 65536, number of loadable words; image may not exceed it.
- gMaxCycles, 0, run-cycle timeout; 0 disables the timeout.

Ports:
- clk  in  1  clock; all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- start_i  in  1  start a load+run sequence.
- ld_valid_i  in  1  load word valid.
- ld_data_i  in  gDataWidth  load word.
- ld_last_i  in  1  marks final word of the image.
- ld_ready_o  out  1  controller accepts a load word.
- cpu_res_o  out  1  active-high CPU reset.
- cpu_mem_addr_i / cpu_mem_data_i  in  gDataWidth  CPU address / write data.
- cpu_mem_ce_ni, cpu_mem_oe_ni, cpu_mem_we_ni  in  1  CPU strobes (active low).
- cpu_mem_data_o  out  gDataWidth  read data to CPU; equals mem_data_i, combinational, always.
- cpu_halt_i, cpu_illegal_i  in  1  CPU status.
- mem_addr_o / mem_data_o  out  gDataWidth  memory address / write data.
- mem_data_i  in  gDataWidth  memory read data.
- mem_ce_no, mem_oe_no, mem_we_no  out  1  memory strobes (active low).
- busy_o, done_o  out  1  sequence active / finished with halt.
- err_o  out  2  0 none, 1 illegal, 2 timeout, 3 overflow.
- cycle_cnt_o  out  32  CPU run cycles.
- load_cnt_o  out  gDataWidth+1  words loaded.

Behaviour:
- Reset (async): state IDLE; cpu_res_o=1; ld_ready_o=0; mem strobes all 1; mem_addr_o/mem_data_o=0; busy_o=0, done_o=0, err_o=0; cycle_cnt_o=0; load_cnt_o=0.
  - Reset mid-LOAD or mid-RUN aborts immediately to these values.
- States: IDLE, LOAD, RELEASE, RUN, HALTED, FAULT.
- IDLE:
  - cpu_res_o=1; bus idle.
  - start_i → LOAD; clear cycle_cnt_o, load_cnt_o, err_o, done_o; word address=0.
- LOAD:
  - busy_o=1; ld_ready_o=1.
  - Handshake when ld_valid_i&ld_ready_o. In that same cycle, combinationally:
    - mem_addr_o=address, mem_data_o=ld_data_i;
    - mem_ce_no=0, mem_we_no=0, mem_oe_no=1.
  - At the clock edge after a handshake, address and load_cnt_o increment.
  - Cycles with no valid: strobes all 1.
  - ld_last_i on a handshake word → RELEASE.
  - Handshake at address gMemWords-1 without ld_last_i → write is performed, then FAULT with err_o=3.
  - ld_last_i at gMemWords-1 is legal → RELEASE.
- RELEASE:
  - Exactly 1 cycle; cpu_res_o=1; bus idle; ld_ready_o=0.
  - → RUN.
- RUN:
  - cpu_res_o=0.
  - Mem port mirrors CPU port combinationally: addr, data, ce, oe, we.
  - cycle_cnt_o increments every RUN cycle, saturating at 2^32-1.
  - Exit priority, evaluated each cycle:
    1. cpu_illegal_i → FAULT, err_o=1.
    2. cpu_halt_i → HALTED, done_o=1.
    3. gMaxCycles≠0 and cycle_cnt_o==gMaxCycles-1 → FAULT, err_o=2. Final cycle_cnt_o=gMaxCycles.
  - The exit cycle itself is counted.
- HALTED / FAULT:
  - cpu_res_o=1 from the next cycle; bus idle; busy_o=0.
  - err_o, done_o and counters hold.
  - start_i → LOAD with clears as in IDLE.
- start_i is ignored in LOAD, RELEASE and RUN.
- ld_ready_o=0 outside LOAD. ld_valid_i outside LOAD is ignored.
- All state-dependent outputs decode from the registered state; only mem/ld bus muxing is combinational.

Test Plan:
1. Load & halt: start_i; stream 0x1111,0x2222,0x3333 (last on third) with valid held high; CPU asserts halt in its 5th RUN cycle.
   - Required: three write cycles at addr 0,1,2 with matching data.
   - Required: one RELEASE cycle, then cpu_res_o=0.
   - Required: HALTED, done_o=1, err_o=0, load_cnt_o=3, cycle_cnt_o=5.
2. Gapped stream: valid pattern 1,0,0,1,1 (last on fifth cycle).
   - Required: writes only in valid cycles; addresses contiguous 0..2; strobes high during gaps.
3. Illegal + halt same cycle in RUN.
   - Required: FAULT, err_o=1, done_o=0, cpu_res_o=1 next cycle.
4. Timeout: gMaxCycles=10; CPU never halts.
   - Required: FAULT after 10 RUN cycles; err_o=2, cycle_cnt_o=10.
5. Overflow: gMemWords=4; stream 5 words, last on the 5th.
   - Required: 4 writes (addr 0..3), then FAULT, err_o=3, load_cnt_o=4, ld_ready_o=0.
6. Reset mid-RUN, then rerun from HALTED.
   - Required: reset mid-RUN gives all reset values immediately.
   - Required: start_i in HALTED clears counters and reloads from addr 0.
